// File: rtl/helper_axis_stream_generator.sv
// Synthesizable AXI-Stream test source: counter/LFSR/constant/alternating data,
// finite or free-running bursts, periodic TLAST and deterministic valid throttling.
module helper_axis_stream_generator #(
    parameter int DATA_WIDTH   = 10,
    parameter int COUNT_WIDTH  = 16,
    parameter int LAST_PERIOD  = 16,
    parameter int STALL_PERIOD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [DATA_WIDTH-1:0]  seed,
    input  logic [COUNT_WIDTH-1:0] beat_count,
    output logic                   output_valid,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic                   output_last,
    input  logic                   output_ready,
    output logic                   done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_STALL, S_DONE} state_t;

    localparam logic [31:0]            LFSR_MASK = 32'h80200003;
    localparam logic [COUNT_WIDTH-1:0] LAST_M1   = COUNT_WIDTH'(LAST_PERIOD - 1);
    localparam logic [COUNT_WIDTH-1:0] STALL_M1  = COUNT_WIDTH'(STALL_PERIOD - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    state_t                 state;
    logic [1:0]             mode_q;
    logic [DATA_WIDTH-1:0]  seed_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] beat_idx;
    logic [COUNT_WIDTH-1:0] phase;
    logic [COUNT_WIDTH-1:0] stall_cnt;
    logic [31:0]            lfsr;
    logic                   pending;

    logic                   hs;
    logic                   is_final;
    logic [COUNT_WIDTH-1:0] next_idx;
    logic [COUNT_WIDTH-1:0] next_phase;
    logic [31:0]            lfsr_next;
    logic [31:0]            seed_load;
    logic [DATA_WIDTH-1:0]  next_data;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

    // TLAST for a beat at LAST phase ph and burst index idx of a cnt-beat burst
    function automatic logic last_for(input logic [COUNT_WIDTH-1:0] ph,
                                      input logic [COUNT_WIDTH-1:0] idx,
                                      input logic [COUNT_WIDTH-1:0] cnt);
        return ((LAST_PERIOD != 0) && (ph == LAST_M1)) ||
               ((cnt != '0) && (idx == cnt - CNT_ONE));
    endfunction

    // A presented beat stays valid until accepted, even if enable drops
    assign output_valid = (state == S_STREAM) && (enable || pending);
    assign hs           = output_valid && output_ready;
    assign is_final     = (count_q != '0) && (beat_idx == count_q - CNT_ONE);
    assign next_idx     = beat_idx + CNT_ONE;
    assign next_phase   = ((LAST_PERIOD != 0) && (phase == LAST_M1)) ? '0 : phase + CNT_ONE;
    assign lfsr_next    = lfsr_step(lfsr);
    assign seed_load    = (seed_q == '0) ? 32'd1 : 32'(seed_q);

    always_comb begin
        next_data = seed_q;
        case (mode_q)
            2'd0:    next_data = output_data + DATA_WIDTH'(1);
            2'd1:    next_data = lfsr_next[DATA_WIDTH-1:0];
            2'd2:    next_data = seed_q;
            default: next_data = ~output_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mode_q      <= '0;
            seed_q      <= '0;
            count_q     <= '0;
            beat_idx    <= '0;
            phase       <= '0;
            stall_cnt   <= '0;
            lfsr        <= 32'd1;
            pending     <= 1'b0;
            output_data <= '0;
            output_last <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        seed_q  <= seed;
                        count_q <= beat_count;
                        done    <= 1'b0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    beat_idx    <= '0;
                    phase       <= '0;
                    stall_cnt   <= '0;
                    pending     <= 1'b0;
                    lfsr        <= seed_load;
                    output_data <= (mode_q == 2'd1) ? seed_load[DATA_WIDTH-1:0] : seed_q;
                    output_last <= last_for('0, '0, count_q);
                    state       <= S_STREAM;
                end
                S_STREAM: begin
                    if (hs) begin
                        pending     <= 1'b0;
                        beat_idx    <= next_idx;
                        phase       <= next_phase;
                        output_data <= next_data;
                        output_last <= last_for(next_phase, next_idx, count_q);
                        if (mode_q == 2'd1)
                            lfsr <= lfsr_next;
                        if (is_final) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if ((STALL_PERIOD != 0) && (stall_cnt == STALL_M1)) begin
                            stall_cnt <= '0;
                            state     <= S_STALL;
                        end else begin
                            stall_cnt <= stall_cnt + CNT_ONE;
                        end
                    end else begin
                        pending <= output_valid;
                    end
                end
                S_STALL: state <= S_STREAM;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_helper_axis_stream_generator.sv
// Directed, table-driven bench for helper_axis_stream_generator: three instances
// cover default framing, LAST_PERIOD=4 and STALL_PERIOD=3.
module tb_helper_axis_stream_generator;
    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic       enable;
    logic [1:0] mode;
    logic [9:0] seed;
    logic [15:0] beat_count;
    logic       output_ready;

    logic       ov [3];
    logic [9:0] od [3];
    logic       ol [3];
    logic       dn [3];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rdy;
        logic       en;
        logic       ev;
        logic [9:0] ed;
        logic       el;
        logic       edn;
    } vec_t;
    vec_t tbl[$];

    helper_axis_stream_generator #(.DATA_WIDTH(10), .COUNT_WIDTH(16), .LAST_PERIOD(16), .STALL_PERIOD(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .enable(enable), .mode(mode), .seed(seed),
        .beat_count(beat_count), .output_valid(ov[0]), .output_data(od[0]), .output_last(ol[0]),
        .output_ready(output_ready), .done(dn[0]));

    helper_axis_stream_generator #(.DATA_WIDTH(10), .COUNT_WIDTH(16), .LAST_PERIOD(4), .STALL_PERIOD(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .enable(enable), .mode(mode), .seed(seed),
        .beat_count(beat_count), .output_valid(ov[1]), .output_data(od[1]), .output_last(ol[1]),
        .output_ready(output_ready), .done(dn[1]));

    helper_axis_stream_generator #(.DATA_WIDTH(10), .COUNT_WIDTH(16), .LAST_PERIOD(16), .STALL_PERIOD(3)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .enable(enable), .mode(mode), .seed(seed),
        .beat_count(beat_count), .output_valid(ov[2]), .output_data(od[2]), .output_last(ol[2]),
        .output_ready(output_ready), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic en, input logic ev,
                       input logic [9:0] ed, input logic el, input logic edn);
        vec_t v;
        v.rdy = rdy; v.en = en; v.ev = ev; v.ed = ed; v.el = el; v.edn = edn;
        tbl.push_back(v);
    endtask

    // Each row is one clock cycle: drive, settle, compare, then advance past the edge
    task automatic run_tbl(input int sel, input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            output_ready = tbl[i].rdy;
            enable       = tbl[i].en;
            #2;
            chk($sformatf("%s[%0d].valid", tag, i), 32'(ov[sel]), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("%s[%0d].data", tag, i), 32'(od[sel]), 32'(tbl[i].ed));
                chk($sformatf("%s[%0d].last", tag, i), 32'(ol[sel]), 32'(tbl[i].el));
            end
            chk($sformatf("%s[%0d].done", tag, i), 32'(dn[sel]), 32'(tbl[i].edn));
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic do_start(input int sel, input logic [1:0] m, input logic [9:0] s,
                            input logic [15:0] n);
        mode         = m;
        seed         = s;
        beat_count   = n;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.valid%0d", tag, k), 32'(ov[k]), 32'd0);
            chk($sformatf("%s.data%0d", tag, k), 32'(od[k]), 32'd0);
            chk($sformatf("%s.last%0d", tag, k), 32'(ol[k]), 32'd0);
            chk($sformatf("%s.done%0d", tag, k), 32'(dn[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start_v = '0; enable = 1'b1; mode = '0; seed = '0;
        beat_count = '0; output_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Counter mode with wrap at 1023
        do_start(0, 2'd0, 10'd1020, 16'd6);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'd1020, 0, 0);
        add(1, 1, 1, 10'd1021, 0, 0);
        add(1, 1, 1, 10'd1022, 0, 0);
        add(1, 1, 1, 10'd1023, 0, 0);
        add(1, 1, 1, 10'd0,    0, 0);
        add(1, 1, 1, 10'd1,    1, 0);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        run_tbl(0, "cnt");

        // LFSR with zero seed, TLAST every 4th beat
        do_start(1, 2'd1, 10'd0, 16'd8);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'h001, 0, 0);
        add(1, 1, 1, 10'h003, 0, 0);
        add(1, 1, 1, 10'h002, 0, 0);
        add(1, 1, 1, 10'h001, 1, 0);
        add(1, 1, 1, 10'h003, 0, 0);
        add(1, 1, 1, 10'h002, 0, 0);
        add(1, 1, 1, 10'h001, 0, 0);
        add(1, 1, 1, 10'h003, 1, 0);
        add(1, 1, 0, 0, 0, 1);
        run_tbl(1, "lfsr");

        // Backpressure: held beat must not change, no skip or duplicate
        do_start(0, 2'd0, 10'd5, 16'd4);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 10'd5, 0, 0);
        add(0, 1, 1, 10'd5, 0, 0);
        add(0, 1, 1, 10'd5, 0, 0);
        add(1, 1, 1, 10'd5, 0, 0);
        add(1, 1, 1, 10'd6, 0, 0);
        add(1, 1, 1, 10'd7, 0, 0);
        add(1, 1, 1, 10'd8, 1, 0);
        add(1, 1, 0, 0, 0, 1);
        run_tbl(0, "bp");

        // Stall after every 3 beats, none after the final beat
        do_start(2, 2'd0, 10'd100, 16'd7);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'd100, 0, 0);
        add(1, 1, 1, 10'd101, 0, 0);
        add(1, 1, 1, 10'd102, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'd103, 0, 0);
        add(1, 1, 1, 10'd104, 0, 0);
        add(1, 1, 1, 10'd105, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'd106, 1, 0);
        add(1, 1, 0, 0, 0, 1);
        run_tbl(2, "stall");

        // Enable dropped while a beat is pending, free-running burst
        do_start(0, 2'd0, 10'd20, 16'd0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 10'd20, 0, 0);
        add(0, 0, 1, 10'd20, 0, 0);
        add(0, 0, 1, 10'd20, 0, 0);
        add(1, 0, 1, 10'd20, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10'd21, 0, 0);
        add(1, 1, 1, 10'd22, 0, 0);
        run_tbl(0, "en");

        // Start is ignored while streaming: the free-running burst keeps counting
        do_start(0, 2'd2, 10'd500, 16'd2);
        add(1, 1, 1, 10'd24, 0, 0);
        add(1, 1, 1, 10'd25, 0, 0);
        run_tbl(0, "busy");

        // Asynchronous reset mid-burst at beat 3, then restart in constant mode
        do_start(1, 2'd0, 10'd0, 16'd8);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'd0, 0, 0);
        add(1, 1, 1, 10'd1, 0, 0);
        add(1, 1, 1, 10'd2, 0, 0);
        run_tbl(1, "pre");
        #1;
        chk("mid.valid", 32'(ov[1]), 32'd1);
        chk("mid.data", 32'(od[1]), 32'd3);
        rst = 1'b0;
        #1;
        chk_zero("async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_start(1, 2'd2, 10'h2AA, 16'd6);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 10'h2AA, 0, 0);
        add(1, 1, 1, 10'h2AA, 0, 0);
        add(1, 1, 1, 10'h2AA, 0, 0);
        add(1, 1, 1, 10'h2AA, 1, 0);
        add(1, 1, 1, 10'h2AA, 0, 0);
        add(1, 1, 1, 10'h2AA, 1, 0);
        add(1, 1, 0, 0, 0, 1);
        run_tbl(1, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/helper_axis_stream_generator.md
# helper_axis_stream_generator

Parametrised AXI-Stream test source for the verification benches. It replaces the fixed random-only source with selectable data modes, a programmable burst length, periodic TLAST framing and deterministic valid throttling. It drives any AXIS sink under test: FIFOs, coders and predictors. It is a testbench component, but must be synthesizable, with no `$random` and fully reproducible from `seed`.

## Interface
- DATA_WIDTH, 10: output data width, 1..32.
- COUNT_WIDTH, 16: width of `beat_count` and the internal beat counters.
- LAST_PERIOD, 16: `output_last` is asserted on every LAST_PERIOD-th beat; 0 disables periodic TLAST.
- STALL_PERIOD, 0: one idle cycle is inserted after every STALL_PERIOD accepted beats; 0 disables stalls.
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a burst; honoured only in IDLE or DONE.
- enable, input, 1: permission to present new beats; does not retract a presented beat.
- mode, input, 2: data mode, sampled on an accepted `start`.
- seed, input, DATA_WIDTH: initial value, sampled on an accepted `start`.
- beat_count, input, COUNT_WIDTH: beats in the burst, sampled on an accepted `start`; 0 means free-running.
- output_valid, output, 1: AXIS TVALID.
- output_data, output, DATA_WIDTH: AXIS TDATA.
- output_last, output, 1: AXIS TLAST.
- output_ready, input, 1: AXIS TREADY.
- done, output, 1: high in DONE, i.e. after the last beat of a finite burst is accepted.

## Operation
- States and transitions:
  - IDLE: start → LOAD.
  - LOAD: one cycle; takes the sampled values and presents the first beat → STREAM.
  - STREAM: handshake, with a stall due → STALL. Handshake on the final beat → DONE.
  - STALL: one cycle → STREAM.
  - DONE: start → LOAD.
- Handshake is `output_valid && output_ready`.
- `output_valid` = (state is STREAM) and (`enable` or a beat is pending).
- A beat becomes pending when it is first presented with valid high. Once valid is high it must not fall until the handshake (AXIS rule). While pending, data and last must not change.
- Data modes (index k = 0, 1, …):
  - 0, counter: `seed + k` mod 2^DATA_WIDTH. Wraps to 0.
  - 1, LFSR: 32-bit Galois right-shift, mask 32'h80200003. State is loaded with the zero-extended seed; a zero seed is replaced by 1. The state advances once per handshake. Data = state[DATA_WIDTH-1:0].
  - 2, constant: `seed` on every beat.
  - 3, alternating: `seed` on even k, `~seed` on odd k.
- Data advances only on a handshake. It never advances on stalls or when `enable` is low.
- `output_last` is high when either:
  - LAST_PERIOD≠0 and (k mod LAST_PERIOD) = LAST_PERIOD−1, or
  - the current beat is the final beat of a finite burst.
- Counters: the beat index and the stall counter are COUNT_WIDTH wide.
  - The LAST_PERIOD phase counter restarts at every accepted `start`.
  - In free-running mode the beat index wraps silently; it affects nothing except the LAST phase.
- `start` is ignored in LOAD, STREAM and STALL. A new burst requires DONE or IDLE.

## Timing
- Reset values (`rst` low, asynchronous):
  - state = IDLE
  - output_valid = 0
  - output_data = 0
  - output_last = 0
  - done = 0
  - LFSR state = 1
  - all counters = 0
- Latency: with `start` high at edge N, LOAD is entered at N. The first beat is valid at edge N+1 if `enable`=1.
- Throughput: 1 beat/cycle with ready=1, enable=1 and STALL_PERIOD=0.
- With STALL_PERIOD=P: exactly P beats, then one valid=0 cycle. The pattern repeats.
  - No stall is inserted after the final beat of a burst.
- `done` rises the cycle after the final handshake and stays high until the next accepted `start`. It falls on entering LOAD.
- Simultaneous `enable` fall and pending beat: valid is held until the handshake. It then drops.
- Reset asserted mid-burst: all outputs go to reset values immediately. No partial beat is considered delivered.

## Test plan
- **Counter mode with wrap.** DATA_WIDTH=10, mode 0, seed 1020, beat_count 6, ready=1.
  - Data must be 1020, 1021, 1022, 1023, 0, 1.
  - last is set only on the 6th beat.
  - done rises one cycle after the 6th beat.
- **LFSR mode with zero seed.** Mode 1, seed 0, LAST_PERIOD=4, beat_count 8.
  - The first beat must equal 1.
  - Each subsequent beat must match the reference Galois model.
  - last is set on beats 4 and 8.
- **Backpressure.** Mode 0, seed 5. Hold ready=0 for 3 cycles while valid=1.
  - valid, data (5) and last must stay stable.
  - Releasing ready yields 5 then 6, with no duplicated or skipped value.
- **Stall insertion.** STALL_PERIOD=3, beat_count 7, ready=1.
  - The valid pattern must be 1,1,1,0,1,1,1,0,1.
  - Data is contiguous across the gaps.
- **Enable handling.** Drop enable while a beat is pending and ready=0.
  - valid stays high until ready=1.
  - It is then low while enable=0.
  - Resuming continues with the next index.
- **Reset and restart.** Assert rst mid-burst at beat 3.
  - All outputs go to 0 asynchronously, without waiting for a clock edge.
  - After release, a new start with mode 2 and seed 10'h2AA emits 10'h2AA every beat.
  - The LAST phase restarts at 0.
